// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : game_pkg
//  Description : State encodings and key index shared by the game control unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_INIT       = 3'd0;
    localparam state_t ST_SETUP      = 3'd1;
    localparam state_t ST_PLAY_FPGA  = 3'd2;
    localparam state_t ST_PLAY_USER  = 3'd3;
    localparam state_t ST_CHECK      = 3'd4;
    localparam state_t ST_NEXT_ROUND = 3'd5;
    localparam state_t ST_RESULT     = 3'd6;

    localparam int ENTER_KEY = 1;

endpackage
`default_nettype wire

// File: rtl/game_control_if.sv
`default_nettype none
// ============================================================================
//  Module      : game_control_if
//  Description : Strobes and status flags between the control unit and datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
interface game_control_if;
    import game_pkg::*;

    logic   end_FPGA;
    logic   end_User;
    logic   end_time;
    logic   match;
    logic   win;
    logic   R1;
    logic   R2;
    logic   E1;
    logic   E2;
    logic   E3;
    logic   E4;
    logic   SEL;
    state_t state;

    modport master (
        input  end_FPGA, end_User, end_time, match, win,
        output R1, R2, E1, E2, E3, E4, SEL, state
    );

    modport slave (
        output end_FPGA, end_User, end_time, match, win,
        input  R1, R2, E1, E2, E3, E4, SEL, state
    );

endinterface
`default_nettype wire

// File: rtl/game_control_key_edge.sv
`default_nettype none
// ============================================================================
//  Module      : key_edge
//  Description : Synchronizes and debounces an active-low key, pulses on press.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_edge #(
    parameter int P_DEBOUNCE = 250000
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_key_n,
    output logic      o_press
);

    localparam int                 c_CNT_W   = $clog2(P_DEBOUNCE + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(P_DEBOUNCE);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_level;
    logic               r_press;
    logic [c_CNT_W-1:0] r_cnt;
    logic               w_settled;

    // The synchronized level has been stable long enough and differs from the accepted one.
    assign w_settled = (r_cnt == c_CNT_MAX) && (r_sync2 != r_level);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_level <= 1'b1;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;
            if (r_sync1 != r_sync2) begin
                r_cnt <= '0;
            end else if (r_cnt != c_CNT_MAX) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_settled) begin
                r_level <= r_sync2;
            end
            r_press <= w_settled & ~r_sync2;
        end
    end

    assign o_press = r_press;

endmodule
`default_nettype wire

// File: rtl/game_control.sv
`default_nettype none
// ============================================================================
//  Module      : game_control
//  Description : Moore FSM sequencing the memory-game datapath from ENTER presses.
//  Revision    : 1.0 - initial release
// ============================================================================
module game_control
    import game_pkg::*;
#(
    parameter int P_KEY      = 4,
    parameter int P_DEBOUNCE = 250000
) (
    input  wire logic             CLOCK_50,
    input  wire logic             RST_N,
    input  wire logic [P_KEY-1:0] KEY,
    game_control_if.master        gc
);

    state_t r_state;
    state_t w_next;
    logic   r_e4;
    logic   w_enter;
    logic   w_unused_keys;

    assign w_unused_keys = ^KEY;

    key_edge #(
        .P_DEBOUNCE (P_DEBOUNCE)
    ) u_enter_key (
        .clk     (CLOCK_50),
        .rst_n   (RST_N),
        .i_key_n (KEY[ENTER_KEY]),
        .o_press (w_enter)
    );

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_INIT:       w_next = ST_SETUP;
            ST_SETUP:      if (w_enter) w_next = ST_PLAY_FPGA;
            ST_PLAY_FPGA:  if (gc.end_FPGA) w_next = ST_PLAY_USER;
            ST_PLAY_USER: begin
                if (gc.end_time) begin
                    w_next = ST_RESULT;
                end else if (gc.end_User) begin
                    w_next = ST_CHECK;
                end
            end
            ST_CHECK:      w_next = (gc.match && !gc.win) ? ST_NEXT_ROUND : ST_RESULT;
            ST_NEXT_ROUND: w_next = ST_PLAY_FPGA;
            ST_RESULT:     if (w_enter) w_next = ST_INIT;
            default:       w_next = ST_INIT;
        endcase
    end

    // Entries arriving on the cycle the round ends are dropped rather than captured.
    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            r_e4 <= 1'b0;
        end else begin
            r_e4 <= (r_state == ST_PLAY_USER) && w_enter && (w_next == ST_PLAY_USER);
        end
    end

    always_comb begin
        gc.R1  = 1'b0;
        gc.R2  = 1'b0;
        gc.E1  = 1'b0;
        gc.E2  = 1'b0;
        gc.E3  = 1'b0;
        gc.SEL = 1'b0;
        case (r_state)
            ST_INIT: begin
                gc.R1 = 1'b1;
                gc.R2 = 1'b1;
            end
            ST_SETUP:      gc.E1  = 1'b1;
            ST_PLAY_FPGA:  gc.E3  = 1'b1;
            ST_PLAY_USER:  gc.E2  = 1'b1;
            ST_NEXT_ROUND: gc.R2  = 1'b1;
            ST_RESULT:     gc.SEL = 1'b1;
            default: ;
        endcase
    end

    assign gc.E4    = r_e4;
    assign gc.state = r_state;

endmodule
`default_nettype wire
